write_axi256_burst_scheduler: RTL and testbench

Sequences a write_axi256 capture transfer as AXI4 write bursts. Takes a base byte address and a total beat count (32-byte beats on the 256-bit bus) and splits the transfer into bursts that never exceed the burst limit or cross a 4 KB boundary. For each burst it issues the AW request and a matching length command to the W-beat mover. It bounds the number of outstanding write responses and reports completion and error status to the capture control registers.

---
 rtl/write_axi256_burst_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_write_axi256_burst_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_axi256_burst_scheduler.sv
// write_axi256_burst_scheduler
//
// Splits one write_axi256 capture transfer (base byte address + beat count,
// 32-byte beats) into AXI4 write bursts. No burst exceeds MAX_BURST_BEATS
// beats or crosses a 4 KB boundary. For every burst the block issues an AW
// request and a matching length command to the W-beat mover. It also limits
// the number of bursts awaiting a B response to MAX_OUTSTANDING.
//
// Optional feature: define WRITE_AXI256_SCHED_ABORT_EN to stop issuing new
// bursts after the first non-OKAY BRESP. The block then drains the
// outstanding responses and finishes with error set. When the macro is not
// defined, the transfer always runs to completion and error only latches.
//
// Handshake rule: a transfer happens on a rising clock edge where valid and
// ready are both high. Once a valid is raised, it and its payload stay
// unchanged until that handshake. The valid drops in the following cycle.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               one-cycle request, honoured only in IDLE
//   cfg_addr, cfg_beats base byte address (bits [4:0] ignored), total beats
//   busy, done, error   status (busy: not IDLE; done: 1-cycle pulse; error: sticky)
//   aw_*                AW request channel (aw_len = beats - 1)
//   wcmd_*              W-mover command channel (wcmd_len = beats - 1)
//   b_valid/b_ready/b_resp  B response channel
//   outstanding         bursts issued and awaiting a response
//   dbg_state           current FSM state encoding, for observation only
module write_axi256_burst_scheduler #(
    parameter int ADDR_W          = 40,
    parameter int LEN_W           = 32,
    parameter int MAX_BURST_BEATS = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [LEN_W-1:0]  cfg_beats,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR_W-1:0] aw_addr,
    output logic [7:0]        aw_len,
    output logic              wcmd_valid,
    input  logic              wcmd_ready,
    output logic [7:0]        wcmd_len,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp,
    output logic [7:0]        outstanding,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0]       MAX_OUT_C   = 8'(MAX_OUTSTANDING);
    localparam logic [LEN_W-1:0] MAX_BURST_C = LEN_W'(MAX_BURST_BEATS);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [7:0]        r_len_m1;      // current burst length minus 1, so that reset gives aw_len = 0
    logic              r_aw_sent;
    logic              r_wcmd_sent;
    logic              r_committed;   // valids of the current burst have been shown at least once
    logic              r_error;
    logic [7:0]        r_outstanding;

    logic [LEN_W-1:0]  w_room_beats;
    logic [LEN_W-1:0]  w_limit;
    logic [LEN_W-1:0]  w_calc_len;
    logic [8:0]        w_len;
    logic [LEN_W-1:0]  w_rem_after;
    logic              w_b_hs;
    logic              w_b_bad;
    logic              w_abort;
    logic              w_can_issue;
    logic              w_present;
    logic              w_aw_hs;
    logic              w_wcmd_hs;
    logic              w_issue;
    logic              w_accept;

    // Beats left before the next 4 KB boundary. The address is always
    // 32-byte aligned, so the result lies in 1..128.
    assign w_room_beats = LEN_W'((13'd4096 - {1'b0, r_addr[11:0]}) >> 5);
    assign w_limit      = (MAX_BURST_C < w_room_beats) ? MAX_BURST_C : w_room_beats;
    assign w_calc_len   = (r_remaining < w_limit) ? r_remaining : w_limit;

    assign w_len        = {1'b0, r_len_m1} + 9'd1;
    assign w_rem_after  = r_remaining - LEN_W'(w_len);

    assign w_b_hs       = b_valid & b_ready;
    assign w_b_bad      = w_b_hs & (b_resp != 2'b00);

`ifdef WRITE_AXI256_SCHED_ABORT_EN
    // A bad response in this very cycle also counts. This lets abort take
    // effect without waiting a cycle for r_error.
    assign w_abort      = r_error | w_b_bad;
`else
    assign w_abort      = 1'b0;
`endif

    // While in ISSUE, outstanding can only go down. So once the valids are
    // shown, w_can_issue stays true until both handshakes finish.
    assign w_can_issue  = (r_outstanding < MAX_OUT_C);
    assign w_present    = (r_state == S_ISSUE) & w_can_issue & (r_committed | ~w_abort);

    assign aw_valid     = w_present & ~r_aw_sent;
    assign wcmd_valid   = w_present & ~r_wcmd_sent;
    assign w_aw_hs      = aw_valid & aw_ready;
    assign w_wcmd_hs    = wcmd_valid & wcmd_ready;

    // The burst counts as issued in the cycle where the second of its two
    // handshakes completes. Either handshake may be the earlier one.
    assign w_issue      = (r_state == S_ISSUE) & (r_aw_sent | w_aw_hs) & (r_wcmd_sent | w_wcmd_hs);
    assign w_accept     = (r_state == S_IDLE) & start;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (cfg_beats == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                w_next_state = w_abort ? S_DRAIN : S_ISSUE;
            end
            S_ISSUE: begin
                if (w_issue) begin
                    w_next_state = (w_abort || (w_rem_after == '0)) ? S_DRAIN : S_CALC;
                end else if (w_abort && !r_committed) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_outstanding == 8'd0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_len_m1      <= '0;
            r_aw_sent     <= 1'b0;
            r_wcmd_sent   <= 1'b0;
            r_committed   <= 1'b0;
            r_error       <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_addr      <= cfg_addr & ~ADDR_W'(31);
                r_remaining <= cfg_beats;
            end else if (w_issue) begin
                r_addr      <= r_addr + (ADDR_W'(w_len) << 5);
                r_remaining <= w_rem_after;
            end

            if (r_state == S_CALC) begin
                r_len_m1 <= 8'(w_calc_len - LEN_W'(1));
            end

            if (w_issue) begin
                r_aw_sent   <= 1'b0;
                r_wcmd_sent <= 1'b0;
                r_committed <= 1'b0;
            end else if (r_state == S_ISSUE) begin
                r_aw_sent   <= r_aw_sent | w_aw_hs;
                r_wcmd_sent <= r_wcmd_sent | w_wcmd_hs;
                r_committed <= r_committed | w_present;
            end

            case ({w_issue, w_b_hs})
                2'b10:   r_outstanding <= r_outstanding + 8'd1;
                2'b01:   r_outstanding <= r_outstanding - 8'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_accept) begin
                r_error <= 1'b0;
            end else if (w_b_bad) begin
                r_error <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign error       = r_error;
    assign aw_addr     = r_addr;
    assign aw_len      = r_len_m1;
    assign wcmd_len    = r_len_m1;
    assign b_ready     = (r_outstanding != 8'd0);
    assign outstanding = r_outstanding;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_write_axi256_burst_scheduler.sv
// Bench for write_axi256_burst_scheduler. A reference burst list is built
// from the splitting rules using plain arithmetic, and a negedge monitor
// checks every AW/W command and the outstanding count against it.
module tb_write_axi256_burst_scheduler;

    localparam int ADDR_W = 40;
    localparam int LEN_W  = 32;
    localparam int MAXB   = 64;
    localparam int MAXO   = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] cfg_addr;
    logic [LEN_W-1:0]  cfg_beats;
    logic              busy, done, error;
    logic              aw_valid, aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic              wcmd_valid, wcmd_ready;
    logic [7:0]        wcmd_len;
    logic              b_valid, b_ready;
    logic [1:0]        b_resp;
    logic [7:0]        outstanding;
    logic [2:0]        dbg_state;

    always #5 clock = ~clock;

    write_axi256_burst_scheduler #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST_BEATS(MAXB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cfg_addr(cfg_addr), .cfg_beats(cfg_beats),
        .busy(busy), .done(done), .error(error),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .wcmd_valid(wcmd_valid), .wcmd_ready(wcmd_ready), .wcmd_len(wcmd_len),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .outstanding(outstanding), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [ADDR_W+7:0] exp_q[$];    // {addr, len-1} per expected burst
    logic [7:0]        wlen_q[$];   // len-1 per expected W command
    int aw_hs = 0, w_hs = 0, b_hs = 0, b_count = 0;
    bit exp_err = 0;

    // stimulus knobs
    int aw_pct = 100, w_pct = 100, b_pct = 100;
    int b_budget = 0;
    int err_b_idx = -1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference burst split: at most MAXB beats, never across a 4 KB line.
    task automatic model_bursts(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] beats);
        logic [ADDR_W-1:0] a;
        longint rem, room, n;
        int off;
        a   = base & ~ADDR_W'(31);
        rem = longint'(beats);
        while (rem > 0) begin
            off  = int'(a[11:0]);
            room = (4096 - off) / 32;
            n    = rem;
            if (n > MAXB) n = MAXB;
            if (n > room) n = room;
            exp_q.push_back({a, 8'(n - 1)});
            wlen_q.push_back(8'(n - 1));
            a   = a + ADDR_W'(n * 32);
            rem = rem - n;
        end
    endtask

    // ---------------- ready / response drivers ----------------
    initial begin
        aw_ready = 1'b0; wcmd_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
        forever begin
            @(posedge clock); #1;
            aw_ready   = ($urandom_range(99) < aw_pct);
            wcmd_ready = ($urandom_range(99) < w_pct);
            b_valid    = (b_budget > 0) && ($urandom_range(99) < b_pct);
            b_resp     = (b_count == err_b_idx) ? 2'b10 : 2'b00;
        end
    end

    // ---------------- monitor ----------------
    bit                prev_aw_pend = 0, prev_w_pend = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0]        prev_len, prev_wlen;

    initial begin
        logic [ADDR_W+7:0] e;
        int exp_out;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete(); wlen_q.delete();
                aw_hs = 0; w_hs = 0; b_hs = 0;
                prev_aw_pend = 0; prev_w_pend = 0;
                continue;
            end
            exp_out = ((aw_hs < w_hs) ? aw_hs : w_hs) - b_hs;
            check_eq("outstanding", 64'(outstanding), 64'(exp_out));
            check_eq("b_ready", 64'(b_ready), 64'(exp_out != 0));
            if (prev_aw_pend) begin
                check_eq("aw_valid_hold", 64'(aw_valid), 64'd1);
                check_eq("aw_addr_stable", 64'(aw_addr), 64'(prev_addr));
                check_eq("aw_len_stable", 64'(aw_len), 64'(prev_len));
            end
            if (prev_w_pend) begin
                check_eq("wcmd_valid_hold", 64'(wcmd_valid), 64'd1);
                check_eq("wcmd_len_stable", 64'(wcmd_len), 64'(prev_wlen));
            end
            if (aw_valid && aw_ready) begin
                aw_hs++;
                if (exp_q.size() == 0) begin
                    check_eq("aw_extra", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("aw_addr", 64'(aw_addr), 64'(e[ADDR_W+7:8]));
                    check_eq("aw_len", 64'(aw_len), 64'(e[7:0]));
                end
            end
            if (wcmd_valid && wcmd_ready) begin
                w_hs++;
                if (wlen_q.size() == 0) begin
                    check_eq("wcmd_extra", 64'(wlen_q.size()), 64'd1);
                end else begin
                    check_eq("wcmd_len", 64'(wcmd_len), 64'(wlen_q.pop_front()));
                end
            end
            if (b_valid && b_ready) begin
                b_hs++;
                b_count++;
                if (b_resp != 2'b00) exp_err = 1;
                if (b_budget > 0) b_budget--;
            end
            prev_aw_pend = aw_valid && !aw_ready;
            prev_w_pend  = wcmd_valid && !wcmd_ready;
            prev_addr    = aw_addr;
            prev_len     = aw_len;
            prev_wlen    = wcmd_len;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_error"}, 64'(error), 64'd0);
        check_eq({tag, "_aw_valid"}, 64'(aw_valid), 64'd0);
        check_eq({tag, "_wcmd_valid"}, 64'(wcmd_valid), 64'd0);
        check_eq({tag, "_aw_addr"}, 64'(aw_addr), 64'd0);
        check_eq({tag, "_aw_len"}, 64'(aw_len), 64'd0);
        check_eq({tag, "_wcmd_len"}, 64'(wcmd_len), 64'd0);
        check_eq({tag, "_b_ready"}, 64'(b_ready), 64'd0);
        check_eq({tag, "_outstanding"}, 64'(outstanding), 64'd0);
        check_eq({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_idle_outputs(tag);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Pulse start; checks busy at t+1 and the first valids at t+2.
    task automatic start_xfer(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] beats);
        model_bursts(addr, beats);
        exp_err = 0;
        @(posedge clock); #1;
        start = 1'b1; cfg_addr = addr; cfg_beats = beats;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check_eq("busy_t1", 64'(busy), 64'd1);
        check_eq("aw_valid_t1", 64'(aw_valid), 64'd0);
        check_eq("err_clr_t1", 64'(error), 64'd0);
        check_eq("done_t1", 64'(done), 64'(beats == 0));
        if (beats != 0) begin
            @(negedge clock);
            check_eq("aw_valid_t2", 64'(aw_valid), 64'd1);
            check_eq("wcmd_valid_t2", 64'(wcmd_valid), 64'd1);
        end
    endtask

    task automatic wait_done(input int budget, input bit allow_left);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check_eq("error_at_done", 64'(error), 64'(exp_err));
            check_eq("outstanding_at_done", 64'(outstanding), 64'd0);
            @(negedge clock);
            check_eq("busy_after_done", 64'(busy), 64'd0);
            check_eq("done_pulse", 64'(done), 64'd0);
            if (!allow_left) begin
                check_eq("aw_left", 64'(exp_q.size()), 64'd0);
                check_eq("wcmd_left", 64'(wlen_q.size()), 64'd0);
            end
            exp_q.delete(); wlen_q.delete();
        end else begin
            do_reset("recover");
        end
    endtask

    task automatic run_xfer(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] beats);
        start_xfer(addr, beats);
        wait_done(8000, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base;
        int found;
        reset = 1'b1; start = 1'b0; cfg_addr = '0; cfg_beats = '0;
        b_budget = 1000000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle_outputs("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // Four full bursts across 4 KB lines.
        run_xfer(40'h0, 256);
        // Short burst up to the 4 KB line, then the remainder.
        run_xfer(40'hFC0, 10);
        // Unaligned base with ignored low bits; wrap at the top of the address space.
        run_xfer(40'h12_3456_789F, 100);
        run_xfer(40'hFF_FFFF_FF00, 20);

        // Responses held off: issue stops at MAXO outstanding.
        b_budget = 0;
        base = aw_hs;
        start_xfer(40'h0, 640);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (outstanding == 8'(MAXO)) begin found = 1; break; end
        end
        check_eq("reach_max_out", 64'(found), 64'd1);
        repeat (20) @(negedge clock);
        check_eq("max_out_aw_valid", 64'(aw_valid), 64'd0);
        check_eq("max_out_count", 64'(outstanding), 64'(MAXO));
        @(posedge clock); #2;
        check_eq("max_out_aw_hs", 64'(aw_hs - base), 64'(MAXO));
        b_budget = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #2;
            if (aw_hs - base >= MAXO + 1) break;
        end
        repeat (5) @(posedge clock);
        #2;
        check_eq("one_b_one_aw", 64'(aw_hs - base), 64'(MAXO + 1));
        b_budget = 1000000;
        wait_done(4000, 0);

        // AW ready immediately, W command delayed.
        w_pct = 0;
        start_xfer(40'h0, 64);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq("aw_dropped", 64'(aw_valid), 64'd0);
            check_eq("wcmd_held", 64'(wcmd_valid), 64'd1);
            check_eq("out_wait_w", 64'(outstanding), 64'd0);
        end
        @(posedge clock); #2;
        w_pct = 100;
        wait_done(200, 0);

        // Zero-beat transfer: done at t+1, no AW.
        base = aw_hs;
        start_xfer(40'h1000, 0);
        @(negedge clock);
        check_eq("zero_done_pulse", 64'(done), 64'd0);
        check_eq("zero_busy", 64'(busy), 64'd0);
        @(posedge clock); #2;
        check_eq("zero_no_aw", 64'(aw_hs - base), 64'd0);

        // Error response on the first burst, slow AW.
        aw_pct = 25; b_pct = 100;
        err_b_idx = b_count;
        base = aw_hs;
        start_xfer(40'h0, 256);
        wait_done(4000, 1);
        check_eq("error_latched", 64'(exp_err), 64'd1);
`ifdef WRITE_AXI256_SCHED_ABORT_EN
        check_eq("abort_fewer_aw", 64'((aw_hs - base) < 4), 64'd1);
`else
        check_eq("noabort_all_aw", 64'(aw_hs - base), 64'd4);
`endif
        err_b_idx = -1;
        aw_pct = 100;
        run_xfer(40'h2000, 8);

        // Reset in the middle of ISSUE with three bursts outstanding.
        b_budget = 0;
        start_xfer(40'h0, 640);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (outstanding == 8'd3) begin found = 1; break; end
        end
        check_eq("reach_out3", 64'(found), 64'd1);
        do_reset("midreset");
        b_budget = 1000000;
        run_xfer(40'h40, 64);

        // Randomised transfers, with a stray start issued mid-transfer.
        for (int k = 0; k < 8; k++) begin
            aw_pct = $urandom_range(100, 30);
            w_pct  = $urandom_range(100, 30);
            b_pct  = $urandom_range(100, 30);
            start_xfer({$urandom, $urandom}, LEN_W'($urandom_range(300, 1)));
            @(posedge clock); #1;
            start = 1'b1; cfg_addr = {$urandom, $urandom}; cfg_beats = 32'd5;
            @(posedge clock); #1;
            start = 1'b0;
            wait_done(8000, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
